fpdiv_ctrl: RTL

Sequencing controller for the Goldschmidt single-precision divider datapath. The datapath only responds to enables and mux selects; this block issues them. It steps the datapath through these phases:
- initial-approximation multiplies
- ITERS refinement pairs
- remainder capture
It then reports completion, and sits directly beside the divider datapath in the FP unit.

---
 rtl/fpdiv_ctrl_if.sv | 24 ++
 rtl/fpdiv_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between the Goldschmidt divider
// sequencer and the divider datapath it steers.
interface fpdiv_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic [1:0] sel_mux3;
  logic [1:0] sel_mux4;

  // Sequencer side: takes the request, drives enables and mux selects.
  modport master (
    input  start,
    output busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4
  );

  // Requester/datapath side.
  modport slave (
    output start,
    input  busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt single-precision divider datapath.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// NA    | A = N * 0.75 (initial approximation of the numerator path)
// DB    | B = D * 0.75, C = ~B
// ITA   | refinement, A = A * C
// ITB   | refinement, B = B * C, C = ~B; loops to ITA until ITERS pairs
// REM   | rem = D * Q
// DONE  | one-cycle completion; results valid, start may chain directly
//
// Every busy phase holds its selects for MUL_LAT cycles and pulses its
// enable only on the last one, so multiplier results land exactly once.
module fpdiv_ctrl #(
  parameter int ITERS   = 3,
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  fpdiv_ctrl_if.master ctl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NA,
    S_DB,
    S_ITA,
    S_ITB,
    S_REM,
    S_DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MUL_LAT - 1);
  localparam logic [2:0] ITER_LAST = 3'(ITERS - 1);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] wait_cnt;
  logic [2:0] iter_cnt;
  logic       phase_end;
  logic       busy_int;

  assign phase_end = (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Phase wait counter and refinement-pair counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      iter_cnt <= '0;
    end else begin
      if (state_d != state_q) wait_cnt <= '0;
      else if (busy_int)      wait_cnt <= wait_cnt + 2'd1;

      if (state_d == S_NA && state_q != S_NA)      iter_cnt <= '0;
      else if (state_q == S_ITB && state_d != S_ITB) iter_cnt <= iter_cnt + 3'd1;
    end
  end

  // Next-state logic and state-decoded (Moore) outputs.
  always_comb begin
    state_d      = state_q;
    busy_int     = 1'b0;
    ctl.busy     = 1'b0;
    ctl.done     = 1'b0;
    ctl.en_a     = 1'b0;
    ctl.en_b     = 1'b0;
    ctl.en_rem   = 1'b0;
    ctl.sel_mux3 = 2'b00;
    ctl.sel_mux4 = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (ctl.start) state_d = S_NA;
      end
      S_NA: begin
        busy_int = 1'b1;
        ctl.en_a = phase_end;
        if (phase_end) state_d = S_DB;
      end
      S_DB: begin
        busy_int     = 1'b1;
        ctl.sel_mux4 = 2'b01;
        ctl.en_b     = phase_end;
        if (phase_end) state_d = S_ITA;
      end
      S_ITA: begin
        busy_int     = 1'b1;
        ctl.sel_mux3 = 2'b01;
        ctl.sel_mux4 = 2'b10;
        ctl.en_a     = phase_end;
        if (phase_end) state_d = S_ITB;
      end
      S_ITB: begin
        busy_int     = 1'b1;
        ctl.sel_mux3 = 2'b01;
        ctl.sel_mux4 = 2'b11;
        ctl.en_b     = phase_end;
        if (phase_end) state_d = (iter_cnt == ITER_LAST) ? S_REM : S_ITA;
      end
      S_REM: begin
        busy_int     = 1'b1;
        ctl.sel_mux3 = 2'b10;
        ctl.sel_mux4 = 2'b10;
        ctl.en_rem   = phase_end;
        if (phase_end) state_d = S_DONE;
      end
      S_DONE: begin
        ctl.done = 1'b1;
        state_d  = ctl.start ? S_NA : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ctl.busy = busy_int;
  end

endmodule
